// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the decode/operand-fetch stage: MIPS instruction field
// positions, the hard-wired zero register index and the default data width.
package id_operand_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int INSTR_W    = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_operand_stage_reg_file.sv
// 2**ADDR_W x DATA_W general register file: two asynchronous read ports and one
// synchronous write port. Register 0 is never written and always reads zero.
module id_operand_stage_reg_file
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != REG_ZERO)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Reads see the value stored before the current edge's write.
  assign ra_data_o = (ra_addr_i == REG_ZERO) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == REG_ZERO) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: reads rs/rt on accept and presents a registered
// {instruction, regA, regB} bundle. Optional macro WB_BYPASS_EN adds write-through on accept.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               wb_en,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [DATA_W-1:0]  regA,
  output logic [DATA_W-1:0]  regB
);

  // Handshake: a transfer happens on an edge where valid && ready. in_ready is
  // combinational so a full stage refills in the same cycle its bundle drains;
  // out_valid stays high and the payload stays stable until out_ready is seen.

  logic               out_valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  rega_q, regb_q;

  logic [ADDR_W-1:0]  rs, rt, held_rs, held_rt;
  logic [DATA_W-1:0]  rf_a, rf_b, opa, opb;
  logic               accept, wb_live;

  assign rs      = in_instr[RS_MSB:RS_LSB];
  assign rt      = in_instr[RT_MSB:RT_LSB];
  assign held_rs = instr_q[RS_MSB:RS_LSB];
  assign held_rt = instr_q[RT_MSB:RT_LSB];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_live  = wb_en && (wb_addr != REG_ZERO);

  id_operand_stage_reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (rs),
    .ra_data_o (rf_a),
    .rb_addr_i (rt),
    .rb_data_o (rf_b),
    .we_i      (wb_en),
    .wa_i      (wb_addr),
    .wd_i      (wb_data)
  );

`ifdef WB_BYPASS_EN
  // wb_live excludes register 0, so a zero index never picks up write data.
  assign opa = (wb_live && (wb_addr == rs)) ? wb_data : rf_a;
  assign opb = (wb_live && (wb_addr == rt)) ? wb_data : rf_b;
`else
  assign opa = rf_a;
  assign opb = rf_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      rega_q      <= '0;
      regb_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      instr_q     <= in_instr;
      rega_q      <= opa;
      regb_q      <= opb;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      // Stalled bundle tracks writes to its own source registers.
      if (wb_live && (wb_addr == held_rs)) rega_q <= wb_data;
      if (wb_live && (wb_addr == held_rt)) regb_q <= wb_data;
    end
  end

  assign out_valid   = out_valid_q;
  assign instruction = instr_q;
  assign regA        = rega_q;
  assign regB        = regb_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: reference register model plus an
// expected-bundle queue filled on accept and drained when the bundle appears.
module tb_id_operand_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] regA;
  logic [DATA_W-1:0] regB;

  id_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .regA        (regA),
    .regB        (regB)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mdl [32];
  logic [95:0]       exp_q [$];
  logic              exp_valid;
  logic [31:0]       exp_ins;
  logic [DATA_W-1:0] exp_a, exp_b;
  logic              rdy_seen;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    exp_q.delete();
    exp_valid = 1'b0;
    exp_ins   = '0;
    exp_a     = '0;
    exp_b     = '0;
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus; predicts and scoreboards the resulting bundle.
  task automatic step(input logic v, input logic [31:0] ins, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
    logic        acc;
    logic        exp_rdy;
    logic [4:0]  rs, rt;
    logic [31:0] a, b;
    logic [95:0] popped;
    @(negedge clk);
    in_valid = v; in_instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    exp_rdy  = !exp_valid || ordy;
    checks++;
    if (rdy_seen !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %0b expected %0b", rdy_seen, exp_rdy);
    end
    acc = v && exp_rdy;
    if (acc) begin
      rs = ins[25:21];
      rt = ins[20:16];
      a  = (rs == 5'd0) ? 32'd0 : mdl[rs];
      b  = (rt == 5'd0) ? 32'd0 : mdl[rt];
`ifdef WB_BYPASS_EN
      if (we && wa != 5'd0 && wa == rs) a = wd;
      if (we && wa != 5'd0 && wa == rt) b = wd;
`endif
      exp_q.push_back({ins, a, b});
    end else if (exp_valid && ordy) begin
      exp_valid = 1'b0;
    end else if (exp_valid) begin
      if (we && wa != 5'd0 && wa == exp_ins[25:21]) exp_a = wd;
      if (we && wa != 5'd0 && wa == exp_ins[20:16]) exp_b = wd;
    end
    @(posedge clk);
    #1;
    if (we && wa != 5'd0) mdl[wa] = wd;
    if (acc) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: expected queue empty on accept");
      end else begin
        popped    = exp_q.pop_front();
        exp_ins   = popped[95:64];
        exp_a     = popped[63:32];
        exp_b     = popped[31:0];
        exp_valid = 1'b1;
      end
    end
    checks++;
    if (out_valid !== exp_valid) begin
      errors++;
      $display("FAIL out_valid: got %0b expected %0b", out_valid, exp_valid);
    end
    checks++;
    if ({instruction, regA, regB} !== {exp_ins, exp_a, exp_b}) begin
      errors++;
      $display("FAIL bundle: got ins=%h a=%h b=%h expected ins=%h a=%h b=%h",
               instruction, regA, regB, exp_ins, exp_a, exp_b);
    end
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 32'd0, 1'b1, wa, wd, 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    in_valid = 0; in_instr = '0; wb_en = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
    rst_n = 1'b0;
    model_clear();
    #12;
    checks++;
    if ({out_valid, instruction, regA, regB} !== {1'b0, 96'd0}) begin
      errors++;
      $display("FAIL reset_state: got v=%0b ins=%h a=%h b=%h expected all zero",
               out_valid, instruction, regA, regB);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_read();
    wr(5'd1, 32'h0000_0001);
    wr(5'd2, 32'hFFFF_FFFE);
    step(1'b1, 32'h0022_1021, 1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if ({out_valid, instruction, regA, regB} !== {1'b1, 32'h0022_1021, 32'h0000_0001, 32'hFFFF_FFFE}) begin
      errors++;
      $display("FAIL basic_addu: got v=%0b ins=%h a=%h b=%h expected 1 00221021 00000001 fffffffe",
               out_valid, instruction, regA, regB);
    end
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_reg_zero();
    wr(5'd1, 32'h7FFF_FFFF);
    wr(5'd0, 32'h1234_5678);
    step(1'b1, 32'h2401_7FFF, 1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if ({regA, regB} !== {32'd0, 32'h7FFF_FFFF}) begin
      errors++;
      $display("FAIL addiu_r0: got a=%h b=%h expected 00000000 7fffffff", regA, regB);
    end
    // rs = rt = 0 while register 0 is being written in the same cycle
    step(1'b1, 32'h0000_0021, 1'b1, 5'd0, 32'hCAFE_0000, 1'b1);
    checks++;
    if ({regA, regB} !== 64'd0) begin
      errors++;
      $display("FAIL r0_reads_zero: got a=%h b=%h expected 0 0", regA, regB);
    end
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    wr(5'd3, 32'h1111_1111);
    // rs = rt = 3, written in the accept cycle
    step(1'b1, 32'h0063_0021, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b1);
`ifdef WB_BYPASS_EN
    want = 32'hA5A5_A5A5;
`else
    want = 32'h1111_1111;
`endif
    checks++;
    if ({regA, regB} !== {want, want}) begin
      errors++;
      $display("FAIL same_cycle_write: got a=%h b=%h expected %h %h", regA, regB, want, want);
    end
    step(1'b1, 32'h0060_0021, 1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if (regA !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL write_landed: got %h expected a5a5a5a5", regA);
    end
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_stall_refresh();
    wr(5'd4, 32'h0BAD_F00D);
    step(1'b1, 32'h0004_2021, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 32'h0085_3021, 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (rdy_seen !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready: got %0b expected 0", rdy_seen);
    end
    checks++;
    if ({out_valid, instruction, regA, regB} !== {1'b1, 32'h0004_2021, 32'd0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL stall_refresh: got v=%0b ins=%h a=%h b=%h expected 1 00042021 0 deadbeef",
               out_valid, instruction, regA, regB);
    end
    // Writes to an unrelated register and to register 0 leave the bundle alone.
    step(1'b1, 32'h0085_3021, 1'b1, 5'd5, 32'h5555_5555, 1'b0);
    step(1'b1, 32'h0085_3021, 1'b1, 5'd0, 32'h7777_7777, 1'b0);
    checks++;
    if ({instruction, regA, regB} !== {32'h0004_2021, 32'd0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL stall_hold: got ins=%h a=%h b=%h expected 00042021 0 deadbeef",
               instruction, regA, regB);
    end
    // Drain without accept keeps the payload.
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if ({out_valid, regB} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL drain: got v=%0b b=%h expected 0 deadbeef", out_valid, regB);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [4];
    for (int r = 6; r <= 9; r++) wr(5'(r), $urandom);
    for (int i = 0; i < 4; i++) begin
      tbl[i] = {6'd0, 5'($urandom_range(6, 9)), 5'($urandom_range(6, 9)), 16'($urandom)};
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, tbl[i], 1'b0, 5'd0, 32'd0, 1'b1);
      checks++;
      if (rdy_seen !== 1'b1 || instruction !== tbl[i]) begin
        errors++;
        $display("FAIL b2b_%0d: got rdy=%0b ins=%h expected 1 %h", i, rdy_seen, instruction, tbl[i]);
      end
    end
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_reset_midflight();
    wr(5'd1, 32'h0000_00AA);
    step(1'b1, 32'h0021_0821, 1'b0, 5'd0, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({out_valid, instruction, regA, regB} !== {1'b0, 96'd0}) begin
      errors++;
      $display("FAIL async_reset: got v=%0b ins=%h a=%h b=%h expected all zero",
               out_valid, instruction, regA, regB);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h0021_0821, 1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if ({out_valid, regA, regB} !== {1'b1, 64'd0}) begin
      errors++;
      $display("FAIL post_reset_r1: got v=%0b a=%h b=%h expected 1 0 0", out_valid, regA, regB);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_read();
    test_reg_zero();
    test_bypass();
    test_stall_refresh();
    test_back_to_back();
    test_reset_midflight();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
